// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX FIFO write-port arbiter.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Width of the granted-requester idle counter.
  localparam int TMO_W = 16;

  // Index width for N requesters; never less than one bit.
  function automatic int arb_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin picker: first asserted valid at or above rr_ptr, wrapping at N_REQ.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = arb_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at rr_ptr; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr_i) + i) % N_REQ);
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing the UART TX FIFO write port.
// Optional idle-grant timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic               tx_yaz_en_o,
  output logic [7:0]         tx_veri_o,
  output logic               tx_en_o,
  input  logic               tx_fifo_dolu_i,
  input  logic               tx_fifo_bos_i
);

  localparam int IDX_W = arb_clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             tx_en_q, tx_en_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             in_grant;
  logic             gnt_valid, gnt_last;
  logic [7:0]       gnt_data;
  logic             xfer;
  logic             fire_tmo;

  uart_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .valid_i  (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  assign in_grant = (state_q == ARB_GRANT);

  // Select the granted requester's valid/last/data.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx_q == IDX_W'(k)) begin
        gnt_valid = req_valid_i[k];
        gnt_last  = req_last_i[k];
        gnt_data  = req_data_i[8*k +: 8];
      end
    end
  end

  assign xfer = in_grant & gnt_valid & ~tx_fifo_dolu_i;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             idle_cyc;

  // Only cycles where the owner could send but does not count; full-FIFO stalls don't.
  assign idle_cyc = in_grant & ~gnt_valid & ~tx_fifo_dolu_i;
  assign fire_tmo = idle_cyc & (cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  // Idle counter: cleared outside GRANT (so entry starts at 0) and on every transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (!in_grant || xfer) cnt_d = '0;
    else if (idle_cyc)     cnt_d = cnt_q + TMO_W'(1);
  end

  // Idle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign fire_tmo   = 1'b0;
`endif

  // Next-state: grant in IDLE, release on last byte or forced timeout.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    tx_en_d     = en_i | ~tx_fifo_bos_i;
    case (state_q)
      ARB_IDLE: begin
        if (en_i && pick_found) begin
          state_d     = ARB_GRANT;
          grant_idx_d = pick_idx;
        end
      end
      ARB_GRANT: begin
        if ((xfer && gnt_last) || fire_tmo) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDX_W'((int'(grant_idx_q) + 1) % N_REQ);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: owner sees ready when the FIFO has room; write is same-cycle.
  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    if (in_grant) begin
      req_ready_o[grant_idx_q] = ~tx_fifo_dolu_i;
      grant_o                  = N_REQ'(1) << grant_idx_q;
    end
    busy_o      = in_grant;
    timeout_o   = fire_tmo;
    tx_yaz_en_o = xfer;
    tx_veri_o   = xfer ? gnt_data : 8'h00;
    tx_en_o     = tx_en_q;
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      tx_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_en_q     <= tx_en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (N_REQ=3); timeout scenario runs with UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int N = 3;

  logic           clk, rst, en, dolu, bos;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           busy, tmo, yaz, tx_en;
  logic [7:0]     veri;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[N][$];
  logic       fl[N][$];
  int         wr_cyc[$];
  int         tmo_cyc[$];
  int         cyc, n_wr, n_vec, n_err;
  logic [N-1:0] acc;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .grant_o        (grant),
    .busy_o         (busy),
    .timeout_o      (tmo),
    .tx_yaz_en_o    (yaz),
    .tx_veri_o      (veri),
    .tx_en_o        (tx_en),
    .tx_fifo_dolu_i (dolu),
    .tx_fifo_bos_i  (bos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present each requester's queue head.
  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      req_valid[k]        = fq[k].size() > 0;
      req_data[8*k +: 8]  = (fq[k].size() > 0) ? fq[k][0] : 8'h00;
      req_last[k]         = (fq[k].size() > 0) ? fl[k][0] : 1'b0;
    end
  endtask

  // Queue a frame of n bytes (first byte in b[7:0]) and its expected writes.
  task automatic load(input int k, input int n, input logic [23:0] b, input bit last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      fq[k].push_back(b[8*i +: 8]);
      fl[k].push_back(last && (i == n - 1));
      e.id   = k;
      e.data = b[8*i +: 8];
      sb.push_back(e);
    end
    refresh();
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      fl[k].delete();
    end
    sb.delete();
    refresh();
  endtask

  // One clock: monitor at negedge, advance requester queues after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (yaz === 1'b1) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) chk("unexp_wr", 32'(yaz), 32'd0);
      else begin
        e = sb.pop_front();
        chk("wr_data", 32'(veri), 32'(e.data));
        chk("wr_grant", 32'(grant), 32'd1 << e.id);
      end
    end else begin
      chk("veri_zero", 32'(veri), 32'd0);
    end
    if (tmo === 1'b1) tmo_cyc.push_back(cyc);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && fq[k].size() > 0) begin
        fq[k].delete(0);
        fl[k].delete(0);
      end
    end
    refresh();
  endtask

  function automatic bit all_done();
    bit d;
    d = (sb.size() == 0) && (busy == 1'b0);
    for (int k = 0; k < N; k++) if (fq[k].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while (!all_done() && n < max) begin
      step();
      n++;
    end
    chk("drain_done", 32'(all_done()), 32'd1);
  endtask

  task automatic wait_wr(input int target, input int max);
    int n;
    n = 0;
    while (n_wr < target && n < max) begin
      step();
      n++;
    end
    chk("wr_wait", 32'(n_wr >= target), 32'd1);
  endtask

  task automatic chk_rst();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_tmo",   32'(tmo), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_yaz",   32'(yaz), 32'd0);
    chk("rst_veri",  32'(veri), 32'd0);
    chk("rst_txen",  32'(tx_en), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
  endtask

  int gaps[6] = '{0, 1, 3, 4, 6, 7};
  int base, w0;

  initial begin
    rst = 1'b1; en = 1'b1; dolu = 1'b0; bos = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    cyc = 0; n_wr = 0; n_vec = 0; n_err = 0; acc = '0;
    @(posedge clk);
    #1;
    chk_rst();
    step();
    rst = 1'b0;

    // T1: single requester, one-cycle arbitration latency
    load(1, 2, 24'h00_42_41, 1'b1);
    #1;
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_ready", 32'(req_ready), 32'd0);
    step();
    #1;
    chk("t1_grant", 32'(grant), 32'b010);
    chk("t1_busy",  32'(busy), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'b010);
    w0 = n_wr;
    step();
    step();
    #1;
    chk("t1_nwr", 32'(n_wr - w0), 32'd2);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    // rr_ptr now 2: requester 2 beats requester 0
    load(2, 1, 24'h62, 1'b1);
    load(0, 1, 24'h61, 1'b1);
    drain(20);

    // T2: three simultaneous frames, order 0,1,2 with one IDLE cycle between
    do_reset();
    base = wr_cyc.size();
    load(0, 2, 24'h00_A1_A0, 1'b1);
    load(1, 2, 24'h00_B1_B0, 1'b1);
    load(2, 2, 24'h00_C1_C0, 1'b1);
    drain(40);
    if (wr_cyc.size() >= base + 6) begin
      for (int i = 0; i < 6; i++)
        chk("t2_gap", 32'(wr_cyc[base+i] - wr_cyc[base]), 32'(gaps[i]));
    end else begin
      chk("t2_nwr", 32'(wr_cyc.size() - base), 32'd6);
    end

    // T3: full FIFO stalls byte 0x55 for 10 cycles
    do_reset();
    load(0, 3, 24'h56_55_54, 1'b1);
    wait_wr(n_wr + 1, 20);
    dolu = 1'b1;
    repeat (10) begin
      #1;
      chk("t3_ready", 32'(req_ready), 32'd0);
      chk("t3_yaz", 32'(yaz), 32'd0);
      chk("t3_tmo", 32'(tmo), 32'd0);
      step();
    end
    dolu = 1'b0;
    #1;
    chk("t3_yaz_rel", 32'(yaz), 32'd1);
    chk("t3_veri_rel", 32'(veri), 32'h55);
    drain(20);

    // T4: reset mid-frame drops the grant
    load(0, 3, 24'hA2_A1_A0, 1'b1);
    wait_wr(n_wr + 1, 20);
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
    #1;
    chk_rst();
    load(1, 1, 24'h11, 1'b1);
    load(2, 1, 24'h22, 1'b1);
    step();
    #1;
    chk("t4_grant", 32'(grant), 32'b010);
    drain(20);

    // T5: en_i falls mid-frame; frame completes, no new grant, tx_en follows FIFO
    bos = 1'b0;
    load(0, 3, 24'hB2_B1_B0, 1'b1);
    wait_wr(n_wr + 1, 20);
    en = 1'b0;
    load(2, 1, 24'hC0, 1'b1);
    wait_wr(n_wr + 2, 20);
    repeat (5) begin
      step();
      #1;
      chk("t5_grant", 32'(grant), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_txen", 32'(tx_en), 32'd1);
    end
    bos = 1'b1;
    step();
    #1;
    chk("t5_txen_off", 32'(tx_en), 32'd0);
    en = 1'b1;
    drain(20);

`ifdef UART_ARB_TIMEOUT_EN
    // T6: owner goes quiet after a non-last byte; forced release after 8 idle cycles
    do_reset();
    load(0, 1, 24'hD0, 1'b0);
    load(1, 1, 24'hE0, 1'b1);
    wait_wr(n_wr + 1, 20);
    w0   = wr_cyc[wr_cyc.size()-1];
    base = tmo_cyc.size();
    repeat (8) step();
    chk("t6_tmo_cnt", 32'(tmo_cyc.size() - base), 32'd1);
    if (tmo_cyc.size() > base)
      chk("t6_tmo_when", 32'(tmo_cyc[base] - w0), 32'd8);
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    step();
    #1;
    chk("t6_grant1", 32'(grant), 32'b010);
    drain(20);
    chk("t6_tmo_once", 32'(tmo_cyc.size() - base), 32'd1);
`else
    chk("no_tmo", 32'(tmo_cyc.size()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter's TX FIFO write port between N_REQ byte-stream requesters, for example a core console, a debug monitor and a boot loader.
Grants are round-robin and locked per frame, so a requester's frame (up to and including its last byte) is never interleaved with another's.
Drives the transmitter's FIFO write strobe/data and its transmit enable, and watches FIFO full/empty.
Sits between the peripheral bus agents and uart_verici.

Parameters:
N_REQ, 3, number of requesters (2..8)
TIMEOUT_CYC, 65535, idle cycles of the granted requester before grant is forcibly released (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
en_i  input  1  arbiter enable; low = no new grants
req_valid_i  input  N_REQ  per-requester byte valid
req_data_i  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
req_last_i  input  N_REQ  byte is last of frame
req_ready_o  output  N_REQ  byte accepted when valid&ready
grant_o  output  N_REQ  one-hot current owner; 0 when idle
busy_o  output  1  a frame is in progress (state GRANT)
timeout_o  output  1  one-cycle pulse on forced release
tx_yaz_en_o  output  1  FIFO write strobe to transmitter
tx_veri_o  output  8  FIFO write data
tx_en_o  output  1  transmitter enable
tx_fifo_dolu_i  input  1  transmitter FIFO full
tx_fifo_bos_i  input  1  transmitter FIFO empty

Behaviour:
- Single clock clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - Registers: state=IDLE, grant_idx=0, rr_ptr=0, idle counter=0, tx_en_o=0.
  - Outputs: grant_o=0, busy_o=0, timeout_o=0, req_ready_o=0, tx_yaz_en_o=0, tx_veri_o=0.
- Reset mid-frame drops the grant immediately. No further writes occur, and a partial frame may remain in the FIFO.
- FSM states:
  - IDLE: if en_i and any req_valid_i, pick the first valid index searching upward from rr_ptr (wrapping at N_REQ). Register it as grant_idx and go to GRANT. Arbitration latency is 1 cycle; no byte is accepted in IDLE.
  - GRANT: ready[grant_idx] = !tx_fifo_dolu_i, combinational; all other ready bits are 0.
    - Transfer = valid[grant_idx] & ready.
    - On a transfer, in the same cycle: tx_yaz_en_o=1 and tx_veri_o = req_data_i slice of grant_idx (both combinational).
    - Transfer with last → IDLE, rr_ptr = (grant_idx+1) mod N_REQ.
- tx_veri_o = 0 whenever tx_yaz_en_o = 0.
- en_i deasserted during GRANT: the current frame still completes, then the FSM stays in IDLE.
- tx_en_o is registered: tx_en_o <= en_i | !tx_fifo_bos_i. Queued bytes still drain after en_i falls.
- Full FIFO stalls the requester indefinitely (ready=0). A full-FIFO stall never counts toward timeout.
- Simultaneous valids in IDLE: the lowest index at or above rr_ptr wins. Each requester waits at most N_REQ-1 frames.
- Back-to-back frames: IDLE must be visited for one cycle between frames, even when the same requester re-requests.
- The granted requester may drop valid mid-frame; the grant is held.
- grant_o = one-hot(grant_idx) in GRANT, 0 in IDLE.

Optional Feature:
UART_ARB_TIMEOUT_EN:
- Defined:
  - A 16-bit counter increments in GRANT each cycle where valid[grant_idx]=0 and tx_fifo_dolu_i=0. It clears on transfer and on entry to GRANT.
  - When counter == TIMEOUT_CYC-1 and that cycle has no transfer: → IDLE, rr_ptr advances as for a completed frame, and timeout_o pulses for 1 cycle.
- Undefined: no counter; timeout_o tied 0; the grant is held until last.

Decomposition:
- Package uart_arb_pkg: state encoding localparams (ARB_IDLE=1'b0, ARB_GRANT=1'b1), TIMEOUT counter width (16), function for clog2 of N_REQ.
- One combinational sub-module, uart_rr_picker (inputs valid vector and rr_ptr; outputs found flag and index). It is instantiated once.
- FSM, counter and muxing stay in uart_tx_arbiter.

Test Plan:
1. N_REQ=3, req1 only, frame 0x41,0x42(last), FIFO never full → grant_o=3'b010 one cycle after valid; tx_yaz_en_o pulses with 0x41 then 0x42; busy_o falls the cycle after last; rr_ptr=2.
2. All three valid at once, each sends a 2-byte frame, rr_ptr=0 → frame order 0,1,2; no interleaving; exactly one IDLE cycle between frames.
3. Hold tx_fifo_dolu_i=1 for 10 cycles mid-frame at byte 0x55 → req_ready_o=0 for those cycles, no write; 0x55 is written the cycle dolu falls; timeout_o stays 0.
4. Assert rst_i for 1 cycle during GRANT after 1 of 3 bytes → next cycle all outputs are at reset values, grant_o=0; a following request is granted to the lowest valid index ≥ 0.
5. en_i=0 while req0 mid-frame → frame completes; req2 valid remains ungranted until en_i=1; tx_en_o stays 1 until tx_fifo_bos_i=1.
6. UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=8: req0 sends 1 non-last byte then drops valid → after 8 idle cycles timeout_o pulses once, state=IDLE, a pending req1 is granted next.
